// File: rtl/dff_pipe_vld_pkg.sv
// Shared definitions for the dff_pipe_vld delay line family.
// Holds default sizing constants, the reset data default, the occupancy
// width helper and a packed stage record for SystemVerilog users who want
// to carry a vld/data pair as a single object.

`default_nettype none

package dff_pkg;

    // Default data width and stage count used when a parent does not override them.
    localparam int DFF_DEFAULT_WIDTH = 8;
    localparam int DFF_DEFAULT_DEPTH = 4;

    // Value loaded into every data register while RST is asserted, unless overridden.
    localparam logic [DFF_DEFAULT_WIDTH-1:0] DFF_RST_VAL_DEFAULT = '0;

    // One pipeline stage as seen from outside: valid flag plus its data word.
    typedef struct packed {
        logic                         vld;
        logic [DFF_DEFAULT_WIDTH-1:0] data;
    } dff_stage_t;

    // Bits needed to count from 0 up to and including n.
    function automatic int clog2p1(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dff_pipe_stage.sv
// One stage of the dff_pipe_vld delay line: a valid flop and a data register.
// The valid flop is cleared by RST (async) or SCLR (sync, wins over advance),
// and otherwise follows the incoming valid on every advance edge.
// The data register resets to RST_VAL and is never touched by SCLR; with
// GATE_DATA set it only loads when the incoming valid is high, so bubbles
// leave the last valid word in place.

`default_nettype none

module dff_pipe_stage
    import dff_pkg::*;
#(
    parameter int                 WIDTH     = DFF_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]   RST_VAL   = WIDTH'(DFF_RST_VAL_DEFAULT),
    parameter int                 GATE_DATA = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_adv,
    input  logic             i_sclr,
    input  logic             i_vld,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_data
);

    logic             r_vld;
    logic [WIDTH-1:0] r_data;
    logic             w_dataLoad;

    // Data loads only on a non-flush advance edge, and under gating only for valid words.
    assign w_dataLoad = i_adv && !i_sclr && ((GATE_DATA == 0) || i_vld);

    // Valid flop: flush beats advance, advance beats hold.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_vld <= 1'b0;
        end else if (i_sclr) begin
            r_vld <= 1'b0;
        end else if (i_adv) begin
            r_vld <= i_vld;
        end
    end

    // Data register: reset to RST_VAL, otherwise load when enabled, else hold.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_data <= RST_VAL;
        end else if (w_dataLoad) begin
            r_data <= i_data;
        end
    end

    assign o_vld  = r_vld;
    assign o_data = r_data;

endmodule

`default_nettype wire

// File: rtl/dff_pipe_vld.sv
// dff_pipe_vld: WIDTH-bit, DEPTH-stage stall-able delay line with per-stage
// valid tracking, selectable enable polarity, synchronous flush and optional
// data gating on bubbles.
// Optional feature macro: DFF_PIPE_OCC_EN adds the OCC port and a counter of
// occupied stages; without it the port and counter do not exist and all
// other behaviour is unchanged.
// OUT_VLD/OUT_DATA come straight from the last stage registers.

`default_nettype none

module dff_pipe_vld
    import dff_pkg::*;
#(
    parameter int               WIDTH      = DFF_DEFAULT_WIDTH,
    parameter int               DEPTH      = DFF_DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RST_VAL    = WIDTH'(DFF_RST_VAL_DEFAULT),
    parameter int               EN_ACT_LOW = 0,
    parameter int               GATE_DATA  = 0
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        EN,
    input  logic                        SCLR,
    input  logic                        IN_VLD,
    input  logic [WIDTH-1:0]            IN_DATA,
    output logic                        OUT_VLD,
    output logic [WIDTH-1:0]            OUT_DATA
`ifdef DFF_PIPE_OCC_EN
    ,
    output logic [clog2p1(DEPTH)-1:0]   OCC
`endif
);

    logic             w_adv;
    logic             w_vld  [DEPTH];
    logic [WIDTH-1:0] w_data [DEPTH];

    // Normalise the enable so the rest of the pipe only sees an active-high advance.
    assign w_adv = (EN_ACT_LOW != 0) ? !EN : EN;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             w_inVld;
        logic [WIDTH-1:0] w_inData;

        if (k == 0) begin : g_head
            assign w_inVld  = IN_VLD;
            assign w_inData = IN_DATA;
        end else begin : g_body
            assign w_inVld  = w_vld[k-1];
            assign w_inData = w_data[k-1];
        end

        dff_pipe_stage #(
            .WIDTH     (WIDTH),
            .RST_VAL   (RST_VAL),
            .GATE_DATA (GATE_DATA)
        ) u_stage (
            .CLK    (CLK),
            .RST    (RST),
            .i_adv  (w_adv),
            .i_sclr (SCLR),
            .i_vld  (w_inVld),
            .i_data (w_inData),
            .o_vld  (w_vld[k]),
            .o_data (w_data[k])
        );
    end

    assign OUT_VLD  = w_vld[DEPTH-1];
    assign OUT_DATA = w_data[DEPTH-1];

`ifdef DFF_PIPE_OCC_EN
    localparam int OCC_W = clog2p1(DEPTH);

    logic [OCC_W-1:0] r_occ;

    // Occupancy tracks set valid bits: +1 for a word entering, -1 for one leaving the last stage.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_occ <= '0;
        end else if (SCLR) begin
            r_occ <= '0;
        end else if (w_adv) begin
            case ({IN_VLD, w_vld[DEPTH-1]})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign OCC = r_occ;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dff_pipe_vld.sv
// Testbench for dff_pipe_vld.
// Three instances share stimulus: a plain pipe, an active-low-enable pipe
// driven with the inverted enable (so it must behave identically), and a
// data-gated pipe. Every valid word sent on an advance edge is queued as the
// expected output; a monitor pops and compares whenever an OUT_VLD is seen.
// Directed checks cover reset, latency, stall, flush, gating and occupancy.

`timescale 1ns/1ps

module tb_dff_pipe_vld;

    localparam int         WIDTH = 8;
    localparam int         DEPTH = 4;
    localparam logic [7:0] RV    = 8'h5A;

    logic       CLK = 1'b0;
    logic       RST;
    logic       en;
    logic       enInv;
    logic       sclr;
    logic       inVld;
    logic [7:0] inData;

    logic       oVld  [3];
    logic [7:0] oData [3];
`ifdef DFF_PIPE_OCC_EN
    logic [2:0] occA;
    logic [2:0] occP;
    logic [2:0] occG;
`endif

    int         nChecks = 0;
    int         nFails  = 0;
    logic [7:0] expList [$];
    int         rdIdx   [3] = '{0, 0, 0};

    assign enInv = !en;

    always #5 CLK = ~CLK;

    dff_pipe_vld #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(RV), .EN_ACT_LOW(0), .GATE_DATA(0)) dutA (
        .CLK(CLK), .RST(RST), .EN(en), .SCLR(sclr), .IN_VLD(inVld), .IN_DATA(inData),
        .OUT_VLD(oVld[0]), .OUT_DATA(oData[0])
`ifdef DFF_PIPE_OCC_EN
        , .OCC(occA)
`endif
    );

    dff_pipe_vld #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(RV), .EN_ACT_LOW(1), .GATE_DATA(0)) dutP (
        .CLK(CLK), .RST(RST), .EN(enInv), .SCLR(sclr), .IN_VLD(inVld), .IN_DATA(inData),
        .OUT_VLD(oVld[1]), .OUT_DATA(oData[1])
`ifdef DFF_PIPE_OCC_EN
        , .OCC(occP)
`endif
    );

    dff_pipe_vld #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(RV), .EN_ACT_LOW(0), .GATE_DATA(1)) dutG (
        .CLK(CLK), .RST(RST), .EN(en), .SCLR(sclr), .IN_VLD(inVld), .IN_DATA(inData),
        .OUT_VLD(oVld[2]), .OUT_DATA(oData[2])
`ifdef DFF_PIPE_OCC_EN
        , .OCC(occG)
`endif
    );

    // Forget every word still in flight (after a flush or reset).
    task automatic dropInFlight();
        for (int d = 0; d < 3; d++) rdIdx[d] = expList.size();
    endtask

    // Drive one cycle of inputs, queue the expected word if it will enter, then step one edge.
    task automatic applyStimulus(input logic e, input logic s, input logic v, input logic [7:0] dat);
        en     = e;
        sclr   = s;
        inVld  = v;
        inData = dat;
        if (v === 1'b1 && e === 1'b1 && s === 1'b0) expList.push_back(dat);
        @(posedge CLK);
        #1;
        if (s === 1'b1) dropInFlight();
    endtask

    // Compare one instance's outputs against hand-computed values.
    task automatic checkOutput(input string name, input int d, input logic expVld,
                               input logic [7:0] expData, input bit chkData);
        nChecks++;
        if (oVld[d] !== expVld) begin
            nFails++;
            $display("[TB] FAIL %s dut%0d OUT_VLD: got %b, expected %b", name, d, oVld[d], expVld);
        end
        if (chkData) begin
            nChecks++;
            if (oData[d] !== expData) begin
                nFails++;
                $display("[TB] FAIL %s dut%0d OUT_DATA: got %h, expected %h", name, d, oData[d], expData);
            end
        end
    endtask

`ifdef DFF_PIPE_OCC_EN
    // Compare the occupancy count of all three instances.
    task automatic checkOcc(input string name, input logic [2:0] expOcc);
        nChecks++;
        if (occA !== expOcc || occP !== expOcc || occG !== expOcc) begin
            nFails++;
            $display("[TB] FAIL %s OCC: got %0d/%0d/%0d, expected %0d", name, occA, occP, occG, expOcc);
        end
    endtask
`endif

    // Scoreboard monitor: each presented output must be the next queued word for that instance.
    always @(negedge CLK) begin
        if (RST === 1'b0) begin
            for (int d = 0; d < 3; d++) begin
                if (oVld[d] === 1'b1) begin
                    nChecks++;
                    if (rdIdx[d] >= expList.size()) begin
                        nFails++;
                        $display("[TB] FAIL mon dut%0d: unexpected output %h, expected none", d, oData[d]);
                    end else begin
                        if (oData[d] !== expList[rdIdx[d]]) begin
                            nFails++;
                            $display("[TB] FAIL mon dut%0d: got %h, expected %h", d, oData[d], expList[rdIdx[d]]);
                        end
                        rdIdx[d]++;
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        RST    = 1'b1;
        en     = 1'b0;
        sclr   = 1'b0;
        inVld  = 1'b0;
        inData = 8'h00;
        #2;
        for (int d = 0; d < 3; d++) checkOutput("reset_init", d, 1'b0, RV, 1'b1);
`ifdef DFF_PIPE_OCC_EN
        checkOcc("reset_init", 3'd0);
`endif
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        $display("[TB] latency");
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hA5);
        checkOutput("lat_e1", 0, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("lat_e2", 0, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("lat_e3", 0, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        for (int d = 0; d < 3; d++) checkOutput("lat_e4", d, 1'b1, 8'hA5, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("lat_e5", 0, 1'b0, 8'h00, 1'b1);
        checkOutput("lat_e5_gate", 2, 1'b0, 8'hA5, 1'b1);

        $display("[TB] stall");
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h3C);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("stall_pre", 0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'bx, 8'hxx);
            checkOutput("stall_hold", 0, 1'b0, 8'h00, 1'b1);
            checkOutput("stall_hold", 1, 1'b0, 8'h00, 1'b1);
            checkOutput("stall_hold", 2, 1'b0, 8'hA5, 1'b1);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        for (int d = 0; d < 3; d++) checkOutput("stall_emerge", d, 1'b1, 8'h3C, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("stall_after", 0, 1'b0, 8'h00, 1'b0);
`ifdef DFF_PIPE_OCC_EN
        checkOcc("stall_after", 3'd0);
`endif

        $display("[TB] flush");
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 1'b0, 1'b1, 8'(i));
        checkOutput("fill_full", 0, 1'b1, 8'h01, 1'b1);
`ifdef DFF_PIPE_OCC_EN
        checkOcc("fill_full", 3'd4);
`endif
        applyStimulus(1'b1, 1'b1, 1'b1, 8'hEE);
        for (int d = 0; d < 3; d++) checkOutput("flush", d, 1'b0, 8'h01, 1'b1);
`ifdef DFF_PIPE_OCC_EN
        checkOcc("flush", 3'd0);
`endif
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
            checkOutput("flush_drain", 0, 1'b0, 8'h00, 1'b0);
        end

        $display("[TB] flush while stalled");
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h31);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h32);
`ifdef DFF_PIPE_OCC_EN
        checkOcc("two_in", 3'd2);
`endif
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h33);
`ifdef DFF_PIPE_OCC_EN
        checkOcc("flush_stalled", 3'd0);
`endif
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
            checkOutput("flush_stalled_drain", 1, 1'b0, 8'h00, 1'b0);
        end

        $display("[TB] gating");
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h11);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h77);
        for (int d = 0; d < 3; d++) checkOutput("gate_out", d, 1'b1, 8'h11, 1'b1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'h77);
            checkOutput("gate_bubble", 0, 1'b0, 8'h77, 1'b1);
            checkOutput("gate_bubble", 1, 1'b0, 8'h77, 1'b1);
            checkOutput("gate_bubble", 2, 1'b0, 8'h11, 1'b1);
        end

        $display("[TB] reset mid-stream");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b1, 8'h21 + 8'(i));
        checkOutput("rst_full", 0, 1'b1, 8'h21, 1'b1);
`ifdef DFF_PIPE_OCC_EN
        checkOcc("rst_full", 3'd4);
`endif
        RST = 1'b1;
        dropInFlight();
        #2;
        for (int d = 0; d < 3; d++) checkOutput("rst_async", d, 1'b0, RV, 1'b1);
`ifdef DFF_PIPE_OCC_EN
        checkOcc("rst_async", 3'd0);
`endif
        @(posedge CLK);
        #1;
        for (int d = 0; d < 3; d++) checkOutput("rst_held", d, 1'b0, RV, 1'b1);
        RST = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h99);
        checkOutput("rst_rec1", 0, 1'b0, RV, 1'b1);
`ifdef DFF_PIPE_OCC_EN
        checkOcc("rst_rec1", 3'd1);
`endif
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("rst_rec2", 0, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("rst_rec3", 0, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        for (int d = 0; d < 3; d++) checkOutput("rst_rec4", d, 1'b1, 8'h99, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("rst_rec_end", 0, 1'b0, 8'h00, 1'b0);

        for (int d = 0; d < 3; d++) begin
            nChecks++;
            if (rdIdx[d] != expList.size()) begin
                nFails++;
                $display("[TB] FAIL drain dut%0d: consumed %0d words, expected %0d", d, rdIdx[d], expList.size());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
